// File: rtl/id_ex_mem_stages_if.sv
// Handshake bundle between fetch, the ID/EX/MEM stages and writeback.
// The design takes the slave side; fetch/writeback (or a bench) drive master.
interface id_ex_mem_stages_if;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_npc;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic [31:0] wb_writedata;
    logic        mem_pcsrc;
    logic [31:0] mem_branch_target;
    logic        mem_wb_regwrite;
    logic        mem_wb_memtoreg;
    logic [31:0] mem_wb_read_data;
    logic [31:0] mem_wb_alu_result;
    logic [4:0]  mem_wb_rd;

    modport slave (
        input  if_id_instr, if_id_npc,
        input  wb_rd, wb_regwrite, wb_writedata,
        output mem_pcsrc, mem_branch_target,
        output mem_wb_regwrite, mem_wb_memtoreg,
        output mem_wb_read_data, mem_wb_alu_result, mem_wb_rd
    );

    modport master (
        output if_id_instr, if_id_npc,
        output wb_rd, wb_regwrite, wb_writedata,
        input  mem_pcsrc, mem_branch_target,
        input  mem_wb_regwrite, mem_wb_memtoreg,
        input  mem_wb_read_data, mem_wb_alu_result, mem_wb_rd
    );
endinterface

// File: rtl/id_ex_mem_stages.sv
// Decode, execute and memory stages of the MIPS-subset pipeline,
// holding the ID/EX, EX/MEM and MEM/WB registers, register file and data memory.
module id_ex_mem_stages (
    input  logic                  clk,
    input  logic                  rst,
    id_ex_mem_stages_if.slave     bus
);
    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] npc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } idex_t;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic        branch;
        logic        memread;
        logic        memwrite;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [31:0] target;
        logic [4:0]  dst;
    } exmem_t;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  dst;
    } memwb_t;

    logic [31:0] rf_q [32];
    logic [31:0] dmem_q [256];

    idex_t  idex_d,  idex_q;
    exmem_t exmem_d, exmem_q;
    memwb_t memwb_d, memwb_q;

    ctrl_t       dec;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt;
    logic [31:0] alu_b, alu_res, mem_rdata;

    assign opcode = bus.if_id_instr[31:26];
    assign rs     = bus.if_id_instr[25:21];
    assign rt     = bus.if_id_instr[20:16];

    // Main control decode; unknown opcodes become a NOP.
    always_comb begin
        dec = '0;
        unique case (opcode)
            6'h00:   dec = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10};
            6'h23:   dec = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
            6'h2B:   dec = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
            6'h04:   dec = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
            default: dec = '0;
        endcase
    end

    // Register reads with write-through so a same-cycle writeback is seen.
    always_comb begin
        idex_d      = '0;
        idex_d.ctrl = dec;
        idex_d.npc  = bus.if_id_npc;
        idex_d.imm  = {{16{bus.if_id_instr[15]}}, bus.if_id_instr[15:0]};
        idex_d.rt   = rt;
        idex_d.rd   = bus.if_id_instr[15:11];
        if (rs == 5'd0)
            idex_d.rd1 = '0;
        else if (bus.wb_regwrite && bus.wb_rd == rs)
            idex_d.rd1 = bus.wb_writedata;
        else
            idex_d.rd1 = rf_q[rs];
        if (rt == 5'd0)
            idex_d.rd2 = '0;
        else if (bus.wb_regwrite && bus.wb_rd == rt)
            idex_d.rd2 = bus.wb_writedata;
        else
            idex_d.rd2 = rf_q[rt];
    end

    // Register file write port; r0 stays hard-wired to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (bus.wb_regwrite && bus.wb_rd != 5'd0) begin
            rf_q[bus.wb_rd] <= bus.wb_writedata;
        end
    end

    // ALU with funct decode for R-type, add for memory ops, sub for beq.
    always_comb begin
        alu_b   = idex_q.ctrl.alusrc ? idex_q.imm : idex_q.rd2;
        alu_res = '0;
        unique case (idex_q.ctrl.aluop)
            2'b00: alu_res = idex_q.rd1 + alu_b;
            2'b01: alu_res = idex_q.rd1 - alu_b;
            2'b10: begin
                unique case (idex_q.imm[5:0])
                    6'h20:   alu_res = idex_q.rd1 + alu_b;
                    6'h22:   alu_res = idex_q.rd1 - alu_b;
                    6'h24:   alu_res = idex_q.rd1 & alu_b;
                    6'h25:   alu_res = idex_q.rd1 | alu_b;
                    6'h2A:   alu_res = ($signed(idex_q.rd1) < $signed(alu_b))
                                       ? 32'd1 : 32'd0;
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    // EX/MEM next state: control pass-through, ALU result, target, dest.
    always_comb begin
        exmem_d          = '0;
        exmem_d.regwrite = idex_q.ctrl.regwrite;
        exmem_d.memtoreg = idex_q.ctrl.memtoreg;
        exmem_d.branch   = idex_q.ctrl.branch;
        exmem_d.memread  = idex_q.ctrl.memread;
        exmem_d.memwrite = idex_q.ctrl.memwrite;
        exmem_d.zero     = (alu_res == 32'd0);
        exmem_d.alu      = alu_res;
        exmem_d.rd2      = idex_q.rd2;
        exmem_d.target   = idex_q.npc + {idex_q.imm[29:0], 2'b00};
        exmem_d.dst      = idex_q.ctrl.regdst ? idex_q.rd : idex_q.rt;
    end

    // Word-addressed data memory; contents survive reset.
    always_ff @(posedge clk) begin
        if (exmem_q.memwrite)
            dmem_q[exmem_q.alu[9:2]] <= exmem_q.rd2;
    end

    // MEM/WB next state with gated combinational memory read.
    always_comb begin
        mem_rdata        = exmem_q.memread ? dmem_q[exmem_q.alu[9:2]] : '0;
        memwb_d          = '0;
        memwb_d.regwrite = exmem_q.regwrite;
        memwb_d.memtoreg = exmem_q.memtoreg;
        memwb_d.rdata    = mem_rdata;
        memwb_d.alu      = exmem_q.alu;
        memwb_d.dst      = exmem_q.dst;
    end

    // Pipeline registers; reset empties the whole pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign bus.mem_pcsrc         = exmem_q.branch & exmem_q.zero;
    assign bus.mem_branch_target = exmem_q.target;
    assign bus.mem_wb_regwrite   = memwb_q.regwrite;
    assign bus.mem_wb_memtoreg   = memwb_q.memtoreg;
    assign bus.mem_wb_read_data  = memwb_q.rdata;
    assign bus.mem_wb_alu_result = memwb_q.alu;
    assign bus.mem_wb_rd         = memwb_q.dst;
endmodule

// File: tb/tb_id_ex_mem_stages.sv
// Scoreboard bench for id_ex_mem_stages: stimulus queues expected
// MEM/WB, branch and reset responses; a monitor retires them on their due edge.
module tb_id_ex_mem_stages;
  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  id_ex_mem_stages_if bus ();

  id_ex_mem_stages dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam int K_WB = 0;
  localparam int K_BR = 1;
  localparam int K_RZ = 2;

  typedef struct {
    int           due;
    int           kind;
    string        name;
    logic [103:0] exp;
  } chk_t;

  chk_t sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  function automatic logic [103:0] act_of(input int kind);
    logic [103:0] v;
    v = '0;
    if (kind == K_WB)
      v[70:0] = {bus.mem_wb_regwrite, bus.mem_wb_memtoreg,
                 bus.mem_wb_read_data, bus.mem_wb_alu_result,
                 bus.mem_wb_rd};
    else if (kind == K_BR)
      v[32:0] = {bus.mem_pcsrc, bus.mem_branch_target};
    else
      v[103:0] = {bus.mem_pcsrc, bus.mem_branch_target,
                  bus.mem_wb_regwrite, bus.mem_wb_memtoreg,
                  bus.mem_wb_read_data, bus.mem_wb_alu_result,
                  bus.mem_wb_rd};
    return v;
  endfunction

  initial begin
    logic [103:0] act;
    forever begin
      @(posedge clk);
      #1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          act = act_of(sb[i].kind);
          n_cmp++;
          if (act !== sb[i].exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h",
                     sb[i].name, act, sb[i].exp);
          end
          sb.delete(i);
        end
      end
    end
  end

  task automatic step(input logic [31:0] ins, input logic [31:0] npc,
                      input logic we, input logic [4:0] rd,
                      input logic [31:0] wd);
    @(negedge clk);
    bus.if_id_instr  = ins;
    bus.if_id_npc    = npc;
    bus.wb_regwrite  = we;
    bus.wb_rd        = rd;
    bus.wb_writedata = wd;
  endtask

  task automatic exp_wb(input string nm, input logic rw, input logic mtr,
                        input logic [31:0] rdat, input logic [31:0] alu,
                        input logic [4:0] rd);
    chk_t c;
    c.due  = cyc + 3;
    c.kind = K_WB;
    c.name = nm;
    c.exp  = '0;
    c.exp[70:0] = {rw, mtr, rdat, alu, rd};
    sb.push_back(c);
  endtask

  task automatic exp_br(input string nm, input logic pcs,
                        input logic [31:0] tgt);
    chk_t c;
    c.due  = cyc + 2;
    c.kind = K_BR;
    c.name = nm;
    c.exp  = '0;
    c.exp[32:0] = {pcs, tgt};
    sb.push_back(c);
  endtask

  task automatic exp_rz(input string nm);
    chk_t c;
    c.due  = cyc + 1;
    c.kind = K_RZ;
    c.name = nm;
    c.exp  = '0;
    sb.push_back(c);
  endtask

  task automatic nop(input bit chk);
    step(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    if (chk) exp_wb("nop", 1'b1, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    cyc   = 0;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    bus.if_id_instr  = 32'h00221820;
    bus.if_id_npc    = 32'h1234;
    bus.wb_regwrite  = 1'b1;
    bus.wb_rd        = 5'd1;
    bus.wb_writedata = 32'hFFFF_FFFF;

    step(32'h00221820, 32'h1234, 1'b1, 5'd1, 32'hFFFF_FFFF);
    exp_rz("reset_a");
    #1;
    n_cmp++;
    if (bus.mem_pcsrc !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_pcsrc: got %b", bus.mem_pcsrc);
    end
    n_cmp++;
    if (bus.mem_branch_target !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_tgt: got %h", bus.mem_branch_target);
    end
    n_cmp++;
    if (bus.mem_wb_regwrite !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_rw: got %b", bus.mem_wb_regwrite);
    end
    n_cmp++;
    if (bus.mem_wb_alu_result !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_alu: got %h", bus.mem_wb_alu_result);
    end
    n_cmp++;
    if (bus.mem_wb_rd !== 5'd0) begin
      n_bad++;
      $display("FAIL rst_rd: got %h", bus.mem_wb_rd);
    end
    step(32'h10210002, 32'h10, 1'b1, 5'd2, 32'hAAAA_AAAA);
    exp_rz("reset_b");

    step(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst = 1'b0;
    exp_wb("nop0", 1'b1, 1'b0, 32'h0, 32'h0, 5'd0);
    exp_br("nop0_br", 1'b0, 32'h0);
    nop(1);
    nop(1);

    step(32'h0, 32'h0, 1'b1, 5'd1, 32'd5);
    step(32'h0, 32'h0, 1'b1, 5'd2, 32'd3);

    step(32'h00221820, 32'h0, 1'b0, 5'd0, 32'h0);
    exp_wb("add", 1'b1, 1'b0, 32'h0, 32'd8, 5'd3);
    step(32'h00221822, 32'h0, 1'b0, 5'd0, 32'h0);
    exp_wb("sub", 1'b1, 1'b0, 32'h0, 32'd2, 5'd3);
    step(32'h00221824, 32'h0, 1'b0, 5'd0, 32'h0);
    exp_wb("and", 1'b1, 1'b0, 32'h0, 32'd1, 5'd3);
    step(32'h00221825, 32'h0, 1'b0, 5'd0, 32'h0);
    exp_wb("or", 1'b1, 1'b0, 32'h0, 32'd7, 5'd3);
    step(32'h0041182A, 32'h0, 1'b0, 5'd0, 32'h0);
    exp_wb("slt", 1'b1, 1'b0, 32'h0, 32'd1, 5'd3);
    step(32'h0022182A, 32'h0, 1'b0, 5'd0, 32'h0);
    exp_wb("slt_false", 1'b1, 1'b0, 32'h0, 32'd0, 5'd3);
    step(32'h00221821, 32'h0, 1'b0, 5'd0, 32'h0);
    exp_wb("bad_funct", 1'b1, 1'b0, 32'h0, 32'd0, 5'd3);

    step(32'hAC010004, 32'h0, 1'b0, 5'd0, 32'h0);
    exp_wb("sw", 1'b0, 1'b0, 32'h0, 32'd4, 5'd1);
    nop(1);
    nop(1);
    nop(1);
    step(32'h8C040004, 32'h0, 1'b0, 5'd0, 32'h0);
    exp_wb("lw", 1'b1, 1'b1, 32'd5, 32'd4, 5'd4);

    step(32'h10210002, 32'h10, 1'b0, 5'd0, 32'h0);
    exp_br("beq_taken", 1'b1, 32'h18);
    exp_wb("beq_taken_wb", 1'b0, 1'b0, 32'h0, 32'h0, 5'd1);
    step(32'h10220002, 32'h10, 1'b0, 5'd0, 32'h0);
    exp_br("beq_not", 1'b0, 32'h18);
    exp_wb("beq_not_wb", 1'b0, 1'b0, 32'h0, 32'd2, 5'd2);

    step(32'hFC221820, 32'h0, 1'b0, 5'd0, 32'h0);
    exp_br("op3f_br", 1'b0, 32'h6080);
    exp_wb("op3f_wb", 1'b0, 1'b0, 32'h0, 32'd8, 5'd2);

    step(32'h0, 32'h0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    step(32'h00001820, 32'h0, 1'b0, 5'd0, 32'h0);
    exp_wb("r0_zero", 1'b1, 1'b0, 32'h0, 32'h0, 5'd3);

    step(32'h00A03020, 32'h0, 1'b1, 5'd5, 32'd9);
    exp_wb("bypass", 1'b1, 1'b0, 32'h0, 32'd9, 5'd6);

    nop(0);
    nop(0);
    nop(0);
    step(32'h00221820, 32'h0, 1'b0, 5'd0, 32'h0);
    step(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    exp_rz("midreset");
    step(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst = 1'b0;
    step(32'h00221820, 32'h0, 1'b0, 5'd0, 32'h0);
    exp_wb("post_reset_add", 1'b1, 1'b0, 32'h0, 32'h0, 5'd3);

    nop(0);
    nop(0);
    nop(0);
    nop(0);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    while (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no check expected due at %0d",
               sb[0].name, sb[0].due);
      void'(sb.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/id_ex_mem_stages.md
# id_ex_mem_stages

Decode, execute and memory stages of the five-stage MIPS-subset pipeline, with the ID/EX, EX/MEM and MEM/WB pipeline registers. It sits between the instruction fetch stage (IF/ID outputs) and the writeback mux. It returns branch-taken/target to fetch and MEM/WB values to writeback. Writeback results come back in to write the register file.

## Interface
- No parameters.
- clk  in  1  rising-edge clock for all pipeline registers, register file and data memory.
- rst  in  1  asynchronous, active-high reset.
- if_id_instr  in  32  instruction from IF/ID.
- if_id_npc  in  32  PC+4 from IF/ID.
- wb_rd  in  5  writeback destination register.
- wb_regwrite  in  1  writeback register write enable.
- wb_writedata  in  32  writeback data.
- mem_pcsrc  out  1  branch taken (EX/MEM branch AND EX/MEM zero).
- mem_branch_target  out  32  EX/MEM branch target.
- mem_wb_regwrite  out  1  MEM/WB register write enable.
- mem_wb_memtoreg  out  1  MEM/WB: select read data (1) or ALU result (0).
- mem_wb_read_data  out  32  MEM/WB data memory read value.
- mem_wb_alu_result  out  32  MEM/WB ALU result.
- mem_wb_rd  out  5  MEM/WB destination register.

## Operation
- Decode: opcode is instr[31:26], with fields rs[25:21], rt[20:16], rd[15:11], imm[15:0] and funct[5:0]. Control outputs are regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch and aluop.
  - R-type (0x00): 1,0,0,1,0,0,0,10.
  - lw (0x23): 0,1,1,1,1,0,0,00.
  - sw (0x2B): 0,1,0,0,0,1,0,00.
  - beq (0x04): 0,0,0,0,0,0,1,01.
  - Any other opcode: all control zero (NOP).
- Register file: 32x32; two combinational reads (rs, rt); r0 reads 0 and is never written.
  - Write happens at the clock edge when wb_regwrite=1 and wb_rd≠0.
  - Read of a register being written in the same cycle returns wb_writedata (write-through).
- Sign-extend imm to 32 bits.
- ID/EX latches: control, npc, rdata1, rdata2, sign-extended immediate, rt, rd.
- ALU operand B = alusrc ? immediate : rdata2.
- ALU control:
  - aluop 00 → add; 01 → subtract.
  - aluop 10 → decode funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed set-less-than (1/0). Any other funct gives result 0.
- Arithmetic is 32-bit wraparound with no overflow detection. zero = (result==0).
- Branch target = npc + (immediate<<2), truncated to 32 bits.
- Destination = regdst ? rd : rt.
- EX/MEM latches: regwrite, memtoreg, branch, memread, memwrite, zero, alu result, rdata2, target, destination.
- Data memory: 256x32 words, word index = alu_result[9:2]; low two address bits are ignored.
  - Write at the clock edge when EX/MEM memwrite=1, data = EX/MEM rdata2.
  - Read is combinational; value = mem[index] when memread=1, else 0.
  - Contents are not cleared by reset.
- MEM/WB latches: regwrite, memtoreg, read value, alu result, destination.
- No forwarding, stalls or flushing; software inserts NOPs for hazards and branch shadows.

## Timing
- rst asserted: all ID/EX, EX/MEM and MEM/WB registers go to 0 immediately, and all register-file entries go to 0. All outputs read 0.
- Instruction presented on if_id_instr before edge N:
  - Captured into ID/EX at edge N.
  - Captured into EX/MEM at edge N+1; mem_pcsrc and mem_branch_target are valid after N+1.
  - Captured into MEM/WB at edge N+2; writeback outputs are valid after N+2.
  - A store's memory write occurs at edge N+2.
- A register file write at edge M is visible to a decode in the cycle before M (bypass) and all later cycles.
- Reset mid-operation discards all in-flight instructions; register file and pipeline restart empty.

## Test plan
- Reset with nonzero inputs → all outputs 0; after release, a NOP stream (0x00000000 encoded as R-type funct 0) gives regwrite=1 with rd=0, producing no register change.
- Preload r1=5, r2=3 via the wb port. Issue 0x00221820 (add $3,$1,$2) → after edge N+2: alu_result=8, rd=3, regwrite=1, memtoreg=0.
- Same preload, issue in sequence:
  - 0x00221822 (sub) → 2.
  - 0x00221824 (and) → 1.
  - 0x00221825 (or) → 7.
  - 0x0041182A (slt $3,$2,$1) → 1.
- Store then load: 0xAC010004 (sw $1,4($0)), three NOPs, then 0x8C040004 (lw $4,4($0)) → read_data=5, rd=4, memtoreg=1, regwrite=1.
- Branch taken: 0x10210002 (beq $1,$1,+2) with npc=0x10 → mem_pcsrc=1 and target=0x18 after edge N+1. Not taken (beq $1,$2) → mem_pcsrc=0.
- Opcode 0x3F → all controls 0. Write to r0 via the wb port → r0 still reads 0.
- Same-cycle wb write of r5=9 while decoding add $6,$5,$0 → result 9.
